// File: rtl/ml_csea8.sv
// ----------------------------------------------------------------------------
// ml_csea8 - registered 65-bit two's-complement adder, z = x + y + c_in.
//
// Structure: multi-level carry-select adder with 8-bit blocks.
//   block 0      bits [7:0]    single 8-bit ripple adder fed by c_in
//   blocks 1..7  bits [63:8]   8-bit ripple adder pairs (carry-in 0 / 1)
//   block 8      bit  64       1-bit full-adder pair (carry-in 0 / 1)
//   level 1      16-bit groups (1,2) (3,4) (5,6) and a 9-bit group (7,8)
//   level 2      32-bit group (bits 39:8) and 25-bit group (bits 64:40)
//   final        the real carry out of block 0 picks the level-2 candidates.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst_b  in   1   asynchronous active-low reset, clears z (and ovf)
//   x      in  65   operand
//   y      in  65   operand
//   c_in   in   1   carry into bit 0 (x + ~y + 1 gives subtraction)
//   z      out 65   registered sum modulo 2^65
//   ovf    out  1   registered 64-bit signed overflow, z[64] ^ z[63]
//                   (only when ML_CSEA8_OVF_EN is defined)
//
// Configuration macro: ML_CSEA8_OVF_EN adds the ovf port and flop.
// ----------------------------------------------------------------------------
module ml_csea8 (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [64:0] x,
    input  logic [64:0] y,
    input  logic        c_in,
`ifdef ML_CSEA8_OVF_EN
    output logic [64:0] z,
    output logic        ovf
`else
    output logic [64:0] z
`endif
);

    // 8-bit ripple-carry adder; result is {cout, sum[7:0]}.
    function automatic logic [8:0] rca8(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic       ci);
        logic [8:0] r;
        logic       c;
        r = 9'd0;
        c = ci;
        for (int i = 0; i < 8; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[8] = c;
        return r;
    endfunction

    // Combine two 8-bit candidate blocks into a 16-bit candidate group.
    // Inputs are {cout, sum} for carry-in 0 and 1 of the lower and upper
    // block. Result layout: [15:0] sum0, [16] cout0, [32:17] sum1, [33] cout1.
    function automatic logic [33:0] grp16(input logic [8:0] lo0,
                                          input logic [8:0] lo1,
                                          input logic [8:0] hi0,
                                          input logic [8:0] hi1);
        logic [8:0] up0;
        logic [8:0] up1;
        up0 = lo0[8] ? hi1 : hi0;
        up1 = lo1[8] ? hi1 : hi0;
        return {up1[8], up1[7:0], lo1[7:0], up0[8], up0[7:0], lo0[7:0]};
    endfunction

    // Combine two 16-bit candidate groups (grp16 layout) into a 32-bit one.
    // Result layout: [31:0] sum0, [32] cout0, [64:33] sum1, [65] cout1.
    function automatic logic [65:0] grp32(input logic [33:0] lo,
                                          input logic [33:0] hi);
        logic [16:0] hi_c0;
        logic [16:0] hi_c1;
        logic [16:0] up0;
        logic [16:0] up1;
        hi_c0 = {hi[16], hi[15:0]};
        hi_c1 = {hi[33], hi[32:17]};
        up0   = lo[16] ? hi_c1 : hi_c0;
        up1   = lo[33] ? hi_c1 : hi_c0;
        return {up1[16], up1[15:0], lo[32:17], up0[16], up0[15:0], lo[15:0]};
    endfunction

    logic [8:0]  w_b0;
    logic [8:0]  w_r0 [1:7];
    logic [8:0]  w_r1 [1:7];
    logic        w_b8_s0;
    logic        w_b8_s1;
    logic [33:0] w_ga;
    logic [33:0] w_gb;
    logic [33:0] w_gc;
    logic [8:0]  w_gd_s0;
    logic [8:0]  w_gd_s1;
    logic [65:0] w_l2a;
    logic [24:0] w_l2b_s0;
    logic [24:0] w_l2b_s1;
    logic        w_c40;
    logic [64:0] w_sum;
    logic [64:0] r_z;

    assign w_b0 = rca8(x[7:0], y[7:0], c_in);

    genvar g;
    for (g = 1; g < 8; g++) begin : g_blk
        assign w_r0[g] = rca8(x[8*g+7:8*g], y[8*g+7:8*g], 1'b0);
        assign w_r1[g] = rca8(x[8*g+7:8*g], y[8*g+7:8*g], 1'b1);
    end

    // Bit 64: its carry-out is dropped, so only the two sum candidates exist.
    assign w_b8_s0 = x[64] ^ y[64];
    assign w_b8_s1 = ~(x[64] ^ y[64]);

    assign w_ga = grp16(w_r0[1], w_r1[1], w_r0[2], w_r1[2]);
    assign w_gb = grp16(w_r0[3], w_r1[3], w_r0[4], w_r1[4]);
    assign w_gc = grp16(w_r0[5], w_r1[5], w_r0[6], w_r1[6]);
    assign w_gd_s0 = {(w_r0[7][8] ? w_b8_s1 : w_b8_s0), w_r0[7][7:0]};
    assign w_gd_s1 = {(w_r1[7][8] ? w_b8_s1 : w_b8_s0), w_r1[7][7:0]};

    assign w_l2a    = grp32(w_ga, w_gb);
    assign w_l2b_s0 = {(w_gc[16] ? w_gd_s1 : w_gd_s0), w_gc[15:0]};
    assign w_l2b_s1 = {(w_gc[33] ? w_gd_s1 : w_gd_s0), w_gc[32:17]};

    // Final select: real carry ripples across the two level-2 groups.
    assign w_c40         = w_b0[8] ? w_l2a[65] : w_l2a[32];
    assign w_sum[7:0]    = w_b0[7:0];
    assign w_sum[39:8]   = w_b0[8] ? w_l2a[64:33] : w_l2a[31:0];
    assign w_sum[64:40]  = w_c40 ? w_l2b_s1 : w_l2b_s0;

    // Result register, cleared asynchronously by rst_b.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_z <= 65'd0;
        end else begin
            r_z <= w_sum;
        end
    end

    assign z = r_z;

`ifdef ML_CSEA8_OVF_EN
    logic r_ovf;

    // Overflow flag: result sign differs from its 64-bit sign bit.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_sum[64] ^ w_sum[63];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_ml_csea8.sv
// ----------------------------------------------------------------------------
// tb_ml_csea8 - scoreboard bench for ml_csea8. The driver pushes the expected
// sum (plain 65-bit arithmetic) each time an operand set is captured; a
// monitor pops and compares one cycle later. Reset behaviour is checked
// directly. ovf is checked when ML_CSEA8_OVF_EN is defined.
// ----------------------------------------------------------------------------
module tb_ml_csea8;

    logic        clk;
    logic        rst_b;
    logic [64:0] x;
    logic [64:0] y;
    logic        c_in;
    logic [64:0] z;
    logic        ovf_s;

    typedef struct packed {
        logic [64:0] z;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   errors;

`ifdef ML_CSEA8_OVF_EN
    ml_csea8 dut (
        .clk   (clk),
        .rst_b (rst_b),
        .x     (x),
        .y     (y),
        .c_in  (c_in),
        .z     (z),
        .ovf   (ovf_s)
    );
`else
    ml_csea8 dut (
        .clk   (clk),
        .rst_b (rst_b),
        .x     (x),
        .y     (y),
        .c_in  (c_in),
        .z     (z)
    );
    assign ovf_s = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer sum truncated to 65 bits; overflow when the
    // 65-bit result's top two bits disagree.
    function automatic exp_t model(input logic [64:0] a, input logic [64:0] b,
                                   input logic c);
        logic [65:0] full;
        exp_t        e;
        full  = {1'b0, a} + {1'b0, b} + {65'd0, c};
        e.z   = full[64:0];
        e.ovf = full[64] ^ full[63];
        return e;
    endfunction

    task automatic check(input string name, input logic [64:0] got,
                         input logic [64:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Apply operands, let the next rising edge capture them, record expectation.
    task automatic issue(input logic [64:0] a, input logic [64:0] b,
                         input logic c);
        x    = a;
        y    = b;
        c_in = c;
        @(posedge clk);
        q.push_back(model(a, b, c));
        #1;
    endtask

    // Monitor: compares the registered output one step after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (z !== e.z) begin
                    errors++;
                    $display("FAIL sum: got %h required %h", z, e.z);
                end
`ifdef ML_CSEA8_OVF_EN
                checks++;
                if (ovf_s !== e.ovf) begin
                    errors++;
                    $display("FAIL ovf: got %b required %b (z=%h)", ovf_s, e.ovf, e.z);
                end
`endif
            end
        end
    end

    initial begin
        logic [63:0] lo_a;
        logic [63:0] lo_b;
        logic [64:0] a;
        logic [64:0] b;
        int          budget;
        checks = 0;
        errors = 0;

        // Reset held: inputs must be ignored.
        rst_b = 1'b0;
        x     = 65'd5;
        y     = 65'd7;
        c_in  = 1'b0;
        #1;
        check("reset_async", z, 65'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", z, 65'd0);
        check("reset_ovf", {64'd0, ovf_s}, 65'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // First edge after release captures current inputs.
        issue(65'd5, 65'd7, 1'b0);
        // Carry through every block.
        issue(65'h0_FFFF_FFFF_FFFF_FFFF, 65'd0, 1'b1);
        // -1 + -1 = -2.
        issue({65{1'b1}}, {65{1'b1}}, 1'b0);
        // Subtraction 100 - 37.
        issue(65'd100, ~65'd37, 1'b1);
        // Largest positive plus itself.
        issue(65'h0_7FFF_FFFF_FFFF_FFFF, 65'h0_7FFF_FFFF_FFFF_FFFF, 1'b0);

        // Random back-to-back regression, sign-extended operands.
        for (int i = 0; i < 30; i++) begin
            lo_a = {$urandom(), $urandom()};
            lo_b = {$urandom(), $urandom()};
            issue({lo_a[63], lo_a}, {lo_b[63], lo_b}, 1'($urandom_range(1, 0)));
        end

        // Random operands with arbitrary bit 64.
        for (int i = 0; i < 8; i++) begin
            lo_a = {$urandom(), $urandom()};
            lo_b = {$urandom(), $urandom()};
            a    = {1'($urandom_range(1, 0)), lo_a};
            b    = {1'($urandom_range(1, 0)), lo_b};
            issue(a, b, 1'($urandom_range(1, 0)));
        end

        // Mid-stream reset: result already captured is discarded at once.
        issue(65'h0_1234_5678_9ABC_DEF0, 65'h0_0FED_CBA9_8765_4321, 1'b1);
        rst_b = 1'b0;
        q.delete();
        #1;
        check("reset_midstream", z, 65'd0);
        x = 65'h0_AAAA_AAAA_AAAA_AAAA;
        y = 65'h0_5555_5555_5555_5555;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ignore_inputs", z, 65'd0);
        @(negedge clk);
        rst_b = 1'b1;
        issue(65'h0_AAAA_AAAA_AAAA_AAAA, 65'h0_5555_5555_5555_5555, 1'b1);

        // Drain the scoreboard with a bounded wait.
        budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
